// File: rtl/adc_scan_if.sv
// ADC front-end handshake bundle used by adc_scan_sequencer.
// The sequencer takes the master side: it drives the request and channel, and receives the ack and data.
interface adc_scan_if #(
  parameter int CH_W   = 3,
  parameter int DATA_W = 16
);
  logic              adc_req_o;
  logic [CH_W-1:0]   adc_ch_o;
  logic              adc_ack_i;
  logic [DATA_W-1:0] adc_data_i;

  modport master (output adc_req_o, adc_ch_o, input adc_ack_i, adc_data_i);
  modport slave  (input adc_req_o, adc_ch_o, output adc_ack_i, adc_data_i);
endinterface

// File: rtl/adc_scan_sequencer.sv
// Periodic or one-shot scan of the masked ADC channels, keeping the latest result for each channel.
// Define SCAN_AVG_EN to average four back-to-back conversions per channel.
module adc_scan_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int CH_W    = 3,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              rst_ni,
  input  logic              cfg_en_i,
  input  logic              cfg_single_i,
  input  logic [NUM_CH-1:0] cfg_ch_mask_i,
  input  logic [15:0]       cfg_period_i,
  input  logic              clr_i,
  adc_scan_if.master        adc,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [NUM_CH-1:0] valid_o,
  output logic              busy_o,
  output logic              scan_done_o,
  output logic              err_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [CH_W:0]     ptr;
  logic [CH_W-1:0]   ptr_idx;
  logic [CH_W-1:0]   ch_q;
  logic [15:0]       period_cnt;
  logic [15:0]       period_ld;
  logic [TO_W-1:0]   to_cnt;
  logic              single_q;
  logic [DATA_W-1:0] result [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic              err_q;
  logic              ack;
  logic              expire;
  logic              ptr_end;
  logic              last_conv;
  logic              redo;
  logic [DATA_W-1:0] store_data;

  assign period_ld = (cfg_period_i == 16'd0) ? 16'd1 : cfg_period_i;
  assign ack       = (state == S_REQ) && adc.adc_ack_i;
  assign expire    = (state == S_REQ) && !adc.adc_ack_i && (to_cnt == TO_W'(TIMEOUT - 1));
  assign ptr_end   = (ptr == (CH_W+1)'(NUM_CH));
  assign ptr_idx   = ptr[CH_W-1:0];

`ifdef SCAN_AVG_EN
  logic [1:0]        avg_cnt;
  logic [DATA_W+1:0] sum_q;
  logic [DATA_W+1:0] sum_next;

  assign sum_next   = sum_q + {2'b00, adc.adc_data_i};
  assign last_conv  = (avg_cnt == 2'd3);
  assign redo       = (avg_cnt != 2'd0);
  assign store_data = sum_next[DATA_W+1:2];

  // A timeout on any of the four conversions throws away the partial sum.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_cnt <= 2'd0;
      sum_q   <= '0;
    end else if (expire || (ack && last_conv)) begin
      avg_cnt <= 2'd0;
      sum_q   <= '0;
    end else if (ack) begin
      avg_cnt <= avg_cnt + 2'd1;
      sum_q   <= sum_next;
    end
  end
`else
  assign last_conv  = 1'b1;
  assign redo       = 1'b0;
  assign store_data = adc.adc_data_i;
`endif

  // The period counter runs from scan start in every non-IDLE state, so a long scan leaves it at 0
  // and the next scan starts straight after a single WAIT cycle.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      ptr        <= '0;
      ch_q       <= '0;
      period_cnt <= 16'd0;
      single_q   <= 1'b0;
    end else begin
      if (state != S_IDLE && period_cnt != 16'd0)
        period_cnt <= period_cnt - 16'd1;
      case (state)
        S_IDLE: begin
          if (cfg_en_i || cfg_single_i) begin
            state      <= S_NEXT;
            period_cnt <= period_ld;
            ptr        <= '0;
            single_q   <= ~cfg_en_i;
          end
        end
        S_NEXT: begin
          if (ptr_end) begin
            state <= S_DONE;
          end else if (redo || cfg_ch_mask_i[ptr_idx]) begin
            state <= S_REQ;
            ch_q  <= ptr_idx;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_REQ: begin
          if (ack) begin
            state <= S_NEXT;
            if (last_conv)
              ptr <= ptr + 1'b1;
          end else if (expire) begin
            state <= S_NEXT;
            ptr   <= ptr + 1'b1;
          end
        end
        S_DONE: state <= (single_q || !cfg_en_i) ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (period_cnt <= 16'd1) begin
            state      <= S_NEXT;
            period_cnt <= period_ld;
            ptr        <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni)
      to_cnt <= '0;
    else if (state != S_REQ)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // A clear and a set in the same cycle leave the flag set.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        result[i] <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= '0;
        err_q   <= 1'b0;
      end
      if (ack && last_conv) begin
        result[ch_q]  <= store_data;
        valid_q[ch_q] <= 1'b1;
      end
      if (expire)
        err_q <= 1'b1;
    end
  end

  assign adc.adc_req_o = (state == S_REQ);
  assign adc.adc_ch_o  = ch_q;
  assign rd_data_o     = result[rd_ch_i];
  assign valid_o       = valid_q;
  assign err_o         = err_q;
  assign busy_o        = (state == S_REQ) || (state == S_NEXT);
  assign scan_done_o   = (state == S_DONE);

endmodule
